// File: rtl/irq_ctrl_n.sv
// irq_ctrl_n: N-channel external interrupt controller with per-channel
// edge/level mode, software mask, fixed priority (lowest index wins) and
// a req/ack/eret handshake toward the CPU exception logic.
// Optional macro IRQ_CTRL_SYNC_EN inserts a 2-flop synchronizer on irq_in.

// Per-channel pending bit: edge channels latch rising edges until acked,
// level channels simply follow the sampled line.
module irq_ctrl_n_chan #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk_gl,
  input  logic rst,
  input  logic smp,
  input  logic smp_q,
  input  logic clr,
  output logic pend
);
  // a new edge in the same cycle as its ack-clear keeps the bit set
  always_ff @(posedge clk_gl) begin
    if (rst)       pend <= 1'b0;
    else if (EDGE) pend <= (smp & ~smp_q) | (pend & ~clr);
    else           pend <= smp;
  end
endmodule

module irq_ctrl_n #(
  parameter int                N_IRQ     = 2,
  parameter int                ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
  parameter logic [N_IRQ-1:0]  EDGE_MODE = {N_IRQ{1'b1}},
  parameter logic [N_IRQ-1:0]  MASK_RST  = {N_IRQ{1'b1}}
) (
  input  logic             clk_gl,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask_out,
  output logic [N_IRQ-1:0] pending_out,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  input  logic             int_ack,
  input  logic             int_eret,
  output logic             in_service
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] irq_s, irq_q, pending, mask, eligible, clr;
  logic [ID_W-1:0]  id_nxt, pri_id;
  logic             pri_vld, ack_fire, cur_ok;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;
  // two-flop synchronizer for asynchronous board-level lines
  always_ff @(posedge clk_gl) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end
  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  // previous-cycle sample used for rising-edge detection
  always_ff @(posedge clk_gl) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq_s;
  end

  // software mask; takes effect from the cycle after the write
  always_ff @(posedge clk_gl) begin
    if (rst)          mask <= MASK_RST;
    else if (mask_we) mask <= mask_wdata;
  end

  assign ack_fire = (state == REQ) && int_ack;
  assign eligible = pending & mask;
  assign cur_ok   = |(eligible & (N_IRQ'(1) << int_id));

  for (genvar i = 0; i < N_IRQ; i++) begin : g_chan
    assign clr[i] = ack_fire && (int_id == ID_W'(i));
    irq_ctrl_n_chan #(.EDGE(EDGE_MODE[i])) u_chan (
      .clk_gl (clk_gl),
      .rst    (rst),
      .smp    (irq_s[i]),
      .smp_q  (irq_q[i]),
      .clr    (clr[i]),
      .pend   (pending[i])
    );
  end

  // fixed priority: scan high to low so the lowest eligible index wins
  always_comb begin
    pri_vld = 1'b0;
    pri_id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pri_vld = 1'b1;
        pri_id  = ID_W'(i);
      end
    end
  end

  // handshake FSM next-state; int_id only changes when leaving IDLE
  always_comb begin
    state_nxt = state;
    id_nxt    = int_id;
    case (state)
      IDLE: begin
        if (pri_vld) begin
          state_nxt = REQ;
          id_nxt    = pri_id;
        end
      end
      REQ: begin
        if (int_ack)      state_nxt = SERVICE;
        else if (!cur_ok) state_nxt = IDLE;
      end
      SERVICE: begin
        if (int_eret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state and registered CPU-facing outputs
  always_ff @(posedge clk_gl) begin
    if (rst) begin
      state      <= IDLE;
      int_id     <= '0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      int_id     <= id_nxt;
      int_req    <= (state_nxt == REQ);
      in_service <= (state_nxt == SERVICE);
    end
  end

  assign mask_out    = mask;
  assign pending_out = pending;
endmodule
